// File: rtl/readout_pkg.sv
// Shared definitions for the readout sequencer: one-hot state encoding, default
// widths and the sample-window compare used by both the readout and exposure sides.
package readout_pkg;

  localparam int ROW_W_DEF = 10;
  localparam int CNT_W_DEF = 32;
  // Wide enough that start+len never wraps for any CNT_W up to 64.
  localparam int WIN_W = 64;

  localparam logic [4:0] ST_IDLE_OH    = 5'b00001;
  localparam logic [4:0] ST_LATCH_OH   = 5'b00010;
  localparam logic [4:0] ST_ROW_OH     = 5'b00100;
  localparam logic [4:0] ST_ROW_END_OH = 5'b01000;
  localparam logic [4:0] ST_RELEASE_OH = 5'b10000;

  typedef enum logic [4:0] {
    IDLE    = ST_IDLE_OH,
    LATCH   = ST_LATCH_OH,
    ROW     = ST_ROW_OH,
    ROW_END = ST_ROW_END_OH,
    RELEASE = ST_RELEASE_OH
  } ro_state_e;

  function automatic logic win_hit(input logic [WIN_W:0] cnt,
                                   input logic [WIN_W:0] start,
                                   input logic [WIN_W:0] len);
    return (cnt >= start) && (cnt < start + len);
  endfunction

endpackage

// File: rtl/ro_window_gen.sv
// Registered SHR/SHS/ADC_START decode. Fed with the next-state count so the
// strobes line up with the row counter value of the cycle they appear in.
module ro_window_gen
  import readout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLKM,
  input  logic             rst,
  input  logic             row_en_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] shr_start_i,
  input  logic [CNT_W-1:0] shr_len_i,
  input  logic [CNT_W-1:0] shs_start_i,
  input  logic [CNT_W-1:0] shs_len_i,
  input  logic [CNT_W-1:0] adc_i,
  output logic             shr_o,
  output logic             shs_o,
  output logic             adc_start_o
);

  logic [WIN_W:0] cnt_x;
  logic           shr_q, shs_q, adc_q;
  logic           shr_d, shs_d, adc_d;

  assign cnt_x = (WIN_W+1)'(cnt_i);

  always_comb begin
    shr_d = row_en_i && win_hit(cnt_x, (WIN_W+1)'(shr_start_i), (WIN_W+1)'(shr_len_i));
    shs_d = row_en_i && win_hit(cnt_x, (WIN_W+1)'(shs_start_i), (WIN_W+1)'(shs_len_i));
    adc_d = row_en_i && (cnt_i >= adc_i);
  end

  always_ff @(posedge CLKM) begin
    if (rst) begin
      shr_q <= 1'b0;
      shs_q <= 1'b0;
      adc_q <= 1'b0;
    end else begin
      shr_q <= shr_d;
      shs_q <= shs_d;
      adc_q <= adc_d;
    end
  end

  assign shr_o       = shr_q;
  assign shs_o       = shs_q;
  assign adc_start_o = adc_q;

endmodule

// File: rtl/readout_seq.sv
// Row-readout sequencer: trigger/re_busy four-phase handshake, per-row strobes and
// a ready/valid row token. Optional frame counter and token tag via RO_FRAME_CNT_EN.
module readout_seq
  import readout_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLKM,
  input  logic             rst,
  input  logic             trigger_i,
  output logic             re_busy,
  input  logic [ROW_W-1:0] NUM_ROW,
  input  logic [CNT_W-1:0] T_row,
  input  logic [CNT_W-1:0] T_shr_start,
  input  logic [CNT_W-1:0] T_shr_len,
  input  logic [CNT_W-1:0] T_shs_start,
  input  logic [CNT_W-1:0] T_shs_len,
  input  logic [CNT_W-1:0] T_adc,
  output logic [ROW_W-1:0] ROWADD_RO,
  output logic             PIXSEL,
  output logic             SHR,
  output logic             SHS,
  output logic             ADC_START,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [ROW_W-1:0] row_idx,
  output logic             frame_done
`ifdef RO_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      tok_tag
`endif
);

  ro_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] nrow_q, nrow_d;
  logic [CNT_W-1:0] trow_q, trow_d;
  logic [CNT_W-1:0] shr_start_q, shr_start_d, shr_len_q, shr_len_d;
  logic [CNT_W-1:0] shs_start_q, shs_start_d, shs_len_q, shs_len_d;
  logic [CNT_W-1:0] adc_q, adc_d;
  logic             re_busy_q, re_busy_d;
  logic             pixsel_q, pixsel_d;
  logic [ROW_W-1:0] rowadd_q, rowadd_d;
  logic             row_valid_q, row_valid_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    nrow_d       = nrow_q;
    trow_d       = trow_q;
    shr_start_d  = shr_start_q;
    shr_len_d    = shr_len_q;
    shs_start_d  = shs_start_q;
    shs_len_d    = shs_len_q;
    adc_d        = adc_q;
    re_busy_d    = re_busy_q;
    row_idx_d    = row_idx_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        re_busy_d = 1'b0;
        if (trigger_i) state_d = LATCH;
      end
      LATCH: begin
        // Timings are frozen here; later input changes only affect the next frame.
        re_busy_d   = 1'b1;
        nrow_d      = NUM_ROW;
        trow_d      = (T_row == '0) ? CNT_W'(1) : T_row;
        shr_start_d = T_shr_start;
        shr_len_d   = T_shr_len;
        shs_start_d = T_shs_start;
        shs_len_d   = T_shs_len;
        adc_d       = T_adc;
        row_d       = '0;
        cnt_d       = '0;
        if (NUM_ROW == '0) begin
          state_d      = RELEASE;
          frame_done_d = 1'b1;
        end else begin
          state_d = ROW;
        end
      end
      ROW: begin
        if (cnt_q == trow_q - CNT_W'(1)) begin
          cnt_d     = '0;
          row_idx_d = row_q;
          state_d   = ROW_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ROW_END: begin
        if (row_ready) begin
          if (row_q == nrow_q - ROW_W'(1)) begin
            state_d      = RELEASE;
            frame_done_d = 1'b1;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = ROW;
          end
        end
      end
      RELEASE: begin
        if (!trigger_i) begin
          re_busy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        re_busy_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with state_q.
    pixsel_d    = (state_d == ROW);
    rowadd_d    = (state_d == ROW) ? row_d : '0;
    row_valid_d = (state_d == ROW_END);
  end

  always_ff @(posedge CLKM) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      nrow_q       <= '0;
      trow_q       <= '0;
      shr_start_q  <= '0;
      shr_len_q    <= '0;
      shs_start_q  <= '0;
      shs_len_q    <= '0;
      adc_q        <= '0;
      re_busy_q    <= 1'b0;
      pixsel_q     <= 1'b0;
      rowadd_q     <= '0;
      row_valid_q  <= 1'b0;
      row_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      nrow_q       <= nrow_d;
      trow_q       <= trow_d;
      shr_start_q  <= shr_start_d;
      shr_len_q    <= shr_len_d;
      shs_start_q  <= shs_start_d;
      shs_len_q    <= shs_len_d;
      adc_q        <= adc_d;
      re_busy_q    <= re_busy_d;
      pixsel_q     <= pixsel_d;
      rowadd_q     <= rowadd_d;
      row_valid_q  <= row_valid_d;
      row_idx_q    <= row_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  ro_window_gen #(
    .CNT_W (CNT_W)
  ) u_win (
    .CLKM        (CLKM),
    .rst         (rst),
    .row_en_i    (state_d == ROW),
    .cnt_i       (cnt_d),
    .shr_start_i (shr_start_d),
    .shr_len_i   (shr_len_d),
    .shs_start_i (shs_start_d),
    .shs_len_i   (shs_len_d),
    .adc_i       (adc_d),
    .shr_o       (SHR),
    .shs_o       (SHS),
    .adc_start_o (ADC_START)
  );

  assign re_busy    = re_busy_q;
  assign PIXSEL     = pixsel_q;
  assign ROWADD_RO  = rowadd_q;
  assign row_valid  = row_valid_q;
  assign row_idx    = row_idx_q;
  assign frame_done = frame_done_q;

`ifdef RO_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge CLKM) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_done_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign tok_tag   = 16'({frame_cnt_q[5:0], row_idx_q});
`endif

endmodule

// File: doc/readout_seq.md
Name: readout_seq

Overview:
Row-readout sequencer at the receiving end of the exposure/readout trigger handshake. It waits for trigger_i from the exposure controller and asserts re_busy while it reads out. For each row it drives the row address, pixel select, reset/signal sample strobes and ADC start, then hands a row-complete token to the downstream row FIFO under ready/valid backpressure. It releases re_busy only after trigger_i has dropped, which closes the four-phase handshake.

Parameters:
ROW_W, 10, width of row address and row count
CNT_W, 32, width of all timing inputs and counters

Ports:
CLKM  in  1  clock
rst  in  1  synchronous, active-high reset
trigger_i  in  1  exposure done; level, held until re_busy seen high
re_busy  out  1  readout in progress (handshake back to exposure)
NUM_ROW  in  ROW_W  rows per frame
T_row  in  CNT_W  cycles per row (sample phase)
T_shr_start  in  CNT_W  SHR window start within row
T_shr_len  in  CNT_W  SHR window length
T_shs_start  in  CNT_W  SHS window start
T_shs_len  in  CNT_W  SHS window length
T_adc  in  CNT_W  ADC_START asserted for cnt >= T_adc
ROWADD_RO  out  ROW_W  row being read
PIXSEL  out  1  row select, high throughout ROW state
SHR  out  1  sample-reset strobe
SHS  out  1  sample-signal strobe
ADC_START  out  1  ADC convert request
row_valid  out  1  row-complete token valid
row_ready  in  1  FIFO accepts token
row_idx  out  ROW_W  index of completed row, stable while row_valid
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- All outputs registered. On reset, state=IDLE and every output is 0, including re_busy. Reset mid-frame aborts immediately; the partial frame is discarded.
- States: IDLE, LATCH, ROW, ROW_END, RELEASE.
- IDLE: re_busy=0. trigger_i=1 -> LATCH.
- LATCH, 1 cycle: re_busy<=1; captures NUM_ROW and all T_* into shadow registers, so mid-frame input changes are ignored. Row counter <=0. NUM_ROW==0 -> RELEASE; otherwise -> ROW. T_row==0 is treated as 1.
- ROW: cnt runs 0..T_row-1. PIXSEL=1; ROWADD_RO=row counter.
  - SHR = (cnt >= T_shr_start && cnt < T_shr_start+T_shr_len).
  - SHS uses the same form with the T_shs_* pair.
  - ADC_START = (cnt >= T_adc).
  - Comparisons are CNT_W+1 bits wide, so sums cannot wrap.
  - Windows lying outside 0..T_row-1 never assert.
  - At cnt==T_row-1 -> ROW_END, cnt<=0.
- ROW_END: strobes and PIXSEL are 0.
  - row_valid=1 and row_idx=row counter, held until row_ready is sampled high. The transfer completes on the cycle row_valid && row_ready.
  - row_valid must never drop without a transfer.
  - If row_ready is already high on entry, ROW_END lasts exactly 1 cycle.
  - After transfer: if row counter == NUM_ROW-1 -> RELEASE with frame_done pulse. Otherwise increment row counter -> ROW.
  - Row counter wraps at 2^ROW_W only if NUM_ROW is 0, and NUM_ROW==0 never reaches ROW.
- RELEASE: re_busy stays 1 while trigger_i=1. When trigger_i=0: re_busy<=0 -> IDLE.
- trigger_i high on the cycle re_busy falls is not possible with a compliant exposure side. Regardless, IDLE requires trigger_i high again to start, so a simultaneous re-trigger starts a new frame 1 cycle later.
- Latency:
  - trigger_i high -> re_busy high: 2 cycles.
  - Per row: T_row + 1 cycles minimum, plus FIFO stall.

Optional Feature:
RO_FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0]. It resets to 0, increments on each frame_done and wraps 65535->0. row_idx is driven onto the token as {frame_cnt[5:0], row} in an added output tok_tag [15:0].
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package readout_pkg holds the state encoding (one-hot localparams), ROW_W/CNT_W defaults and a window-compare function (cnt, start, len) -> bit, which the exposure side may reuse.
- One sub-module, ro_window_gen: registered SHR/SHS/ADC_START decode from cnt and the shadow timings. Everything else stays in readout_seq.

Test Plan:
- Basic frame: NUM_ROW=3, T_row=10, SHR 2/3, SHS 6/2, T_adc=8, row_ready=1.
  - Response: re_busy rises 2 cycles after trigger_i.
  - Per row: SHR at cnt 2-4, SHS at 6-7, ADC_START at 8-9.
  - row_idx 0,1,2; one frame_done; re_busy falls 1 cycle after trigger_i drops.
- Backpressure: row_ready=0 for 5 cycles at row 1 -> row_valid held 6 cycles, row_idx=1 stable, no SHR/SHS during the stall.
- Handshake hold: trigger_i held high 50 cycles after frame end -> re_busy stays 1 until trigger_i=0. No second frame starts.
- Edge timings: NUM_ROW=0 -> re_busy pulse, no row_valid, frame_done=1. T_row=0 -> 1-cycle rows. T_shr_start=0xFFFFFFFF, len=2 -> SHR never asserts.
- Mid-frame reset: rst at row 2 of 5 -> next cycle all outputs 0, state IDLE. A new trigger_i then reads rows from 0.
- RO_FRAME_CNT_EN: 3 frames -> frame_cnt 1,2,3; tok_tag upper bits match frame_cnt during each frame.
